// File: rtl/diffeq_sample_fifo.sv
// Capture stage for the differential-equation solver: samples x/y/u on every
// iteration of a run into a first-word-fall-through FIFO and flags the terminal sample.
module diffeq_sample_fifo #(
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] aport,
   input  logic [31:0] xport,
   input  logic [31:0] yport,
   input  logic [31:0] uport,
   input  logic        out_ready,
   output logic        out_valid,
   output logic [31:0] out_x,
   output logic [31:0] out_y,
   output logic [31:0] out_u,
   output logic        out_last,
   output logic        done,
   output logic [15:0] sample_count,
   output logic [7:0]  overflow_count
);

   // state    | meaning
   // S_IDLE   | after reset, no captures until start
   // S_RUN    | capture one sample per cycle, terminal when x >= a
   // S_DRAIN  | terminal sample stored, waiting for the FIFO to empty
   // S_DONE   | run complete and drained, done held until next start
   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

   state_t state_q, state_d;

   logic [31:0]      mem_x_q [DEPTH];
   logic [31:0]      mem_y_q [DEPTH];
   logic [31:0]      mem_u_q [DEPTH];
   logic [DEPTH-1:0] mem_last_q;
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q;
   logic [15:0]      sample_count_q;
   logic [7:0]       overflow_count_q;

   logic full, pop, term;
   logic push, flush, s_inc, o_inc;

   assign full = (count_q == (AW+1)'(DEPTH));
   assign pop  = out_valid && out_ready;
   assign term = (xport >= aport);

   always_comb begin
      state_d = state_q;
      push    = 1'b0;
      flush   = 1'b0;
      s_inc   = 1'b0;
      o_inc   = 1'b0;
      if (start) begin
         flush   = 1'b1;
         state_d = S_RUN;
      end else begin
         case (state_q)
            S_RUN: begin
               if (!full || pop) begin
                  push  = 1'b1;
                  s_inc = 1'b1;
                  if (term) state_d = S_DRAIN;
               end else if (!term) begin
                  o_inc = 1'b1;
               end
               // A blocked terminal sample is retried: the solver holds its outputs.
            end
            S_DRAIN: begin
               if (count_q == '0 || (count_q == (AW+1)'(1) && pop)) state_d = S_DONE;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sample_count_q   <= '0;
         overflow_count_q <= '0;
      end else if (flush) begin
         sample_count_q   <= '0;
         overflow_count_q <= '0;
      end else begin
         if (s_inc && sample_count_q != 16'hFFFF) sample_count_q <= sample_count_q + 16'd1;
         if (o_inc && overflow_count_q != 8'hFF) overflow_count_q <= overflow_count_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
         if (push && !pop)      count_q <= count_q + (AW+1)'(1);
         else if (!push && pop) count_q <= count_q - (AW+1)'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_x_q[i] <= '0;
            mem_y_q[i] <= '0;
            mem_u_q[i] <= '0;
         end
         mem_last_q <= '0;
      end else if (push) begin
         mem_x_q[wr_ptr_q]    <= xport;
         mem_y_q[wr_ptr_q]    <= yport;
         mem_u_q[wr_ptr_q]    <= uport;
         mem_last_q[wr_ptr_q] <= term;
      end
   end

   assign out_valid      = (count_q != '0);
   assign out_x          = mem_x_q[rd_ptr_q];
   assign out_y          = mem_y_q[rd_ptr_q];
   assign out_u          = mem_u_q[rd_ptr_q];
   assign out_last       = out_valid && mem_last_q[rd_ptr_q];
   assign done           = (state_q == S_DONE);
   assign sample_count   = sample_count_q;
   assign overflow_count = overflow_count_q;

endmodule

// File: tb/tb_diffeq_sample_fifo.sv
// Directed-sequence bench for diffeq_sample_fifo with random sample data,
// checked against a queue-based model of the capture/drain behaviour.
module tb_diffeq_sample_fifo;

   localparam int DEPTH = 8;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        out_ready = 1'b0;
   logic [31:0] aport = '0, xport = '0, yport = '0, uport = '0;
   logic        out_valid, out_last, done;
   logic [31:0] out_x, out_y, out_u;
   logic [15:0] sample_count;
   logic [7:0]  overflow_count;

   diffeq_sample_fifo #(.DEPTH(DEPTH), .AW(3)) dut (
      .clk(clk), .reset(reset), .start(start), .aport(aport),
      .xport(xport), .yport(yport), .uport(uport), .out_ready(out_ready),
      .out_valid(out_valid), .out_x(out_x), .out_y(out_y), .out_u(out_u),
      .out_last(out_last), .done(done), .sample_count(sample_count),
      .overflow_count(overflow_count)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] x, y, u;
      logic        last;
   } smp_t;

   smp_t m_q[$];
   bit   m_run = 0, m_drain = 0, m_done = 0;
   int   m_scnt = 0, m_ocnt = 0;
   int   total = 0, bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      chk("out_valid", 32'(out_valid), 32'(m_q.size() > 0));
      if (m_q.size() > 0) begin
         chk("out_x", out_x, m_q[0].x);
         chk("out_y", out_y, m_q[0].y);
         chk("out_u", out_u, m_q[0].u);
         chk("out_last", 32'(out_last), 32'(m_q[0].last));
      end
      chk("done", 32'(done), 32'(m_done));
      chk("sample_count", 32'(sample_count), 32'(m_scnt));
      chk("overflow_count", 32'(overflow_count), 32'(m_ocnt));
   endtask

   // Advance the model by one clock using the currently driven inputs, then
   // let the DUT take the same edge and compare just after it.
   task automatic cycle();
      bit popped, terminal;
      smp_t s;
      popped = (m_q.size() > 0) && out_ready;
      if (start) begin
         m_q.delete();
         m_scnt = 0; m_ocnt = 0;
         m_run = 1; m_drain = 0; m_done = 0;
      end else begin
         if (popped) void'(m_q.pop_front());
         if (m_run) begin
            terminal = (xport >= aport);
            if (m_q.size() < DEPTH) begin
               s.x = xport; s.y = yport; s.u = uport; s.last = terminal;
               m_q.push_back(s);
               if (m_scnt < 65535) m_scnt++;
               if (terminal) begin
                  m_run = 0; m_drain = 1;
               end
            end else if (!terminal) begin
               if (m_ocnt < 255) m_ocnt++;
            end
         end else if (m_drain && m_q.size() == 0) begin
            m_drain = 0; m_done = 1;
         end
      end
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic do_start();
      start = 1'b1;
      cycle();
      start = 1'b0;
   endtask

   task automatic drive_below();
      xport = $urandom_range(aport - 1, 0);
      yport = $urandom;
      uport = $urandom;
   endtask

   task automatic drain_to_done(input string tag);
      int budget;
      budget = 0;
      out_ready = 1'b1;
      while (!done && budget < 40) begin
         cycle();
         budget++;
      end
      chk(tag, 32'(done), 32'd1);
   endtask

   initial begin
      // reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_last", 32'(out_last), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_x", out_x, 32'd0);
      chk("rst_scnt", 32'(sample_count), 32'd0);
      chk("rst_ocnt", 32'(overflow_count), 32'd0);
      reset = 1'b1;
      xport = 32'd0; aport = 32'd5;
      cycle();

      // nominal run
      aport = 32'd3;
      out_ready = 1'b1;
      do_start();
      for (int i = 0; i < 4; i++) begin
         xport = 32'(i); yport = 32'(10 * (i + 1)); uport = 32'(5 + i);
         cycle();
      end
      chk("nom_not_done_yet", 32'(done), 32'd0);
      cycle();
      chk("nom_done", 32'(done), 32'd1);
      chk("nom_scount", 32'(sample_count), 32'd4);
      chk("nom_ocount", 32'(overflow_count), 32'd0);

      // overflow with blocked terminal sample
      aport = $urandom_range(1 << 20, 1000);
      out_ready = 1'b0;
      do_start();
      for (int i = 0; i < 12; i++) begin
         drive_below();
         cycle();
      end
      xport = aport; yport = $urandom; uport = $urandom;
      repeat (3) cycle();
      chk("ovf_ocount", 32'(overflow_count), 32'd4);
      chk("ovf_scount", 32'(sample_count), 32'd8);
      chk("ovf_held_run", 32'(done), 32'd0);
      drain_to_done("ovf_done");
      chk("ovf_scount_final", 32'(sample_count), 32'd9);

      // full FIFO with simultaneous push and pop across pointer wrap
      aport = $urandom_range(1 << 20, 1000);
      out_ready = 1'b0;
      do_start();
      for (int i = 0; i < DEPTH; i++) begin
         drive_below();
         cycle();
      end
      out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         drive_below();
         cycle();
      end
      chk("full_ocount", 32'(overflow_count), 32'd0);
      chk("full_scount", 32'(sample_count), 32'd18);
      xport = aport + 32'($urandom_range(5, 0));
      drain_to_done("full_done");

      // immediate terminal sample
      aport = 32'd0; xport = 32'd0; yport = $urandom; uport = $urandom;
      out_ready = 1'b0;
      do_start();
      cycle();
      chk("imm_last", 32'(out_last), 32'd1);
      cycle();
      chk("imm_scount", 32'(sample_count), 32'd1);
      drain_to_done("imm_done");

      // restart mid-run with entries queued
      aport = $urandom_range(1 << 20, 1000);
      out_ready = 1'b0;
      do_start();
      for (int i = 0; i < 5; i++) begin
         drive_below();
         cycle();
      end
      do_start();
      chk("rs_valid", 32'(out_valid), 32'd0);
      chk("rs_scount", 32'(sample_count), 32'd0);
      for (int i = 0; i < 6; i++) begin
         drive_below();
         out_ready = 1'($urandom_range(1, 0));
         cycle();
      end
      xport = aport;
      drain_to_done("rs_done");

      // asynchronous reset during drain
      aport = $urandom_range(1 << 20, 1000);
      out_ready = 1'b0;
      do_start();
      for (int i = 0; i < 3; i++) begin
         drive_below();
         cycle();
      end
      xport = aport;
      cycle();
      cycle();
      #3;
      reset = 1'b0;
      #1;
      chk("ar_valid", 32'(out_valid), 32'd0);
      chk("ar_done", 32'(done), 32'd0);
      chk("ar_scount", 32'(sample_count), 32'd0);
      chk("ar_ocount", 32'(overflow_count), 32'd0);
      chk("ar_x", out_x, 32'd0);
      m_q.delete();
      m_scnt = 0; m_ocnt = 0;
      m_run = 0; m_drain = 0; m_done = 0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive_below();
         cycle();
      end
      chk("ar_idle_scount", 32'(sample_count), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/diffeq_sample_fifo.md
# diffeq_sample_fifo

Downstream capture stage for the differential-equation solver. It samples the solver's x/y/u state registers on every iteration of a run and flags the terminal sample (x >= a). Samples are buffered in a DEPTH-entry first-word-fall-through FIFO and handed to a consumer over a valid/ready interface. It reports run completion, accepted-sample count and dropped-sample count.

## Interface
- DEPTH, 8: FIFO entries; power of two, at least 2.
- AW, 3: pointer width; equals log2(DEPTH).
- clk  input  1  rising-edge clock, shared with the solver.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  one-cycle pulse issued in the same cycle the solver's synchronous reset is released; begins a run.
- aport  input  32  solver bound a, unsigned; must remain stable during a run.
- xport, yport, uport  input  32 each  solver state registers, sampled directly.
- out_ready  input  1  consumer accepts the head entry.
- out_valid  output  1  FIFO not empty.
- out_x, out_y, out_u  output  32 each  head entry.
- out_last  output  1  head entry is the terminal sample.
- done  output  1  run complete and FIFO drained; held until the next start.
- sample_count  output  16  samples accepted this run; saturates at 65535.
- overflow_count  output  8  samples dropped this run; saturates at 255.

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE: no captures. start -> RUN.
- RUN, xport < aport (unsigned): push {x,y,u,last=0} this edge. If full and no pop, drop the sample and increment overflow_count.
- RUN, xport >= aport: push {x,y,u,last=1}, then go to DRAIN. If full and no pop, stay in RUN, make no drop, and retry next cycle. Solver outputs are frozen in this condition, so the terminal sample is never lost.
- DRAIN: no captures. Go to DONE on the edge where the FIFO becomes empty, including the edge that pops the last entry.
- DONE: done=1. start -> RUN.
- start in any state (including mid-RUN or DRAIN): empty the FIFO, zero both counters, clear done, enter RUN. Capture in that cycle is suppressed.
- Push rule: a push is accepted when count < DEPTH, or when a pop occurs in the same cycle. Simultaneous push and pop leaves count unchanged.
- Pop rule: a pop occurs when out_valid && out_ready.
- Storage: register array with write pointer, read pointer and a count of width AW+1. Pointers wrap modulo DEPTH.
- Outputs: out_* are read combinationally from the array at the read pointer. Output data is don't-care when out_valid=0.
- Unsigned compare only. No arithmetic is performed on the sample data.

## Timing
- Reset values: state=IDLE, out_valid=0, out_last=0, done=0, sample_count=0, overflow_count=0, pointers=0. out_x/y/u = 0, because the array is reset.
- Capture latency: a sample pushed at edge T is visible on out_* with out_valid=1 immediately after T, provided it is at the head.
- Throughput: one push and one pop per cycle.
- done rises on the edge after the final pop (DRAIN -> DONE).
- Reset assertion is asynchronous and takes effect mid-cycle. Deassertion must be synchronous to clk, which is the integrator's responsibility.
- out_valid, out_x/y/u and out_last change only on clk edges or reset assertion.

## Test plan
- Nominal run: a=3, bench drives x=0,1,2,3 on successive cycles (y=10,20,30,40; u=5,6,7,8), out_ready=1 -> outputs 4 samples in order, out_last only on x=3, sample_count=4, overflow_count=0, done=1 one cycle after the final pop.
- Overflow: DEPTH=8, out_ready=0, 12 cycles with x<a, then x=a -> 8 stored, overflow_count=4, FSM holds in RUN. Raise out_ready -> terminal sample enters on the first pop edge, 9 samples delivered, last on the 9th.
- Full with simultaneous push/pop: FIFO full, out_ready=1, x<a -> count stays 8, no drop, order preserved across pointer wrap.
- Immediate terminal: a=0, x=0 at start -> exactly one sample with out_last=1, then DONE.
- Restart: start asserted mid-RUN with 5 entries queued -> out_valid=0 next cycle, counters 0, new run captures from the following cycle.
- Async reset: reset driven low mid-cycle during DRAIN -> out_valid, done and counters go to 0 before the next clk edge. The FSM is in IDLE after reset is released.
